nonce_scheduler: RTL and testbench

Sequencing controller for the double-SHA miner core. It captures a 512-bit block header, a 256-bit target and a nonce range, then issues one header per nonce to the miner. It checks each returned hash against the target and reports winning nonces with a hold-until-acknowledged handshake. It sits between the header-collection FIFO (read side, `clk` domain) and the miner, replacing the free-running `block_ready && miner_start` launch.

---
 rtl/miner_pkg.sv | 16 +
 rtl/hash_le_cmp.sv | 18 +
 rtl/nonce_scheduler.sv | 160 ++++++++++++++++
 tb/tb_nonce_scheduler.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared widths and state encoding for the miner sequencing blocks.
package miner_pkg;

  localparam int HEADER_W = 512;
  localparam int HASH_W   = 256;
  localparam int NONCE_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    FOUND
  } sched_state_t;

endpackage

// File: rtl/hash_le_cmp.sv
// Registered unsigned a <= b comparator; the result updates only when en is high.
module hash_le_cmp #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         le
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) le <= 1'b0;
    else if (en) le <= (a <= b);
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Issues one header per nonce to the miner, checks each returned hash against
// the target and holds winning nonces until they are acknowledged.
//
// state | meaning
// IDLE  | no sweep; waiting for start
// ISSUE | building the header for the current nonce / launching it
// WAIT  | one job outstanding; counting towards the timeout
// CHECK | registered compare result available; hit or advance
// FOUND | winning nonce held until result_ack
module nonce_scheduler
  import miner_pkg::*;
#(
  parameter int NONCE_LSB      = 96,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [HEADER_W-1:0] header_in,
  input  logic [HASH_W-1:0]   target,
  input  logic [NONCE_W-1:0]  nonce_start,
  input  logic [NONCE_W-1:0]  nonce_end,
  output logic                miner_valid,
  output logic [HEADER_W-1:0] miner_header,
  input  logic                miner_out_valid,
  input  logic [HASH_W-1:0]   miner_hash,
  output logic                busy,
  output logic                result_valid,
  output logic [NONCE_W-1:0]  result_nonce,
  output logic [HASH_W-1:0]   result_hash,
  input  logic                result_ack,
  output logic                done,
  output logic                aborted,
  output logic                timeout_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  sched_state_t        state;
  logic [HEADER_W-1:0] header_q;
  logic [HEADER_W-1:0] launch_hdr;
  logic [HASH_W-1:0]   target_q;
  logic [HASH_W-1:0]   hash_q;
  logic [NONCE_W-1:0]  nonce;
  logic [NONCE_W-1:0]  nonce_end_q;
  logic [CNT_W-1:0]    wait_cnt;
  logic                hash_le;
  logic                capture;
  logic                last;

  assign capture = (state == WAIT) && miner_out_valid;
  assign last    = (nonce == nonce_end_q);

  // On start the header comes straight from the inputs so the launch needs no extra cycle.
  always_comb begin
    launch_hdr = (state == IDLE) ? header_in : header_q;
    launch_hdr[NONCE_LSB +: NONCE_W] = (state == IDLE) ? nonce_start : nonce;
  end

  hash_le_cmp #(.W(HASH_W)) u_cmp (
    .clk (clk),
    .rst (rst),
    .en  (capture),
    .a   (miner_hash),
    .b   (target_q),
    .le  (hash_le)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      header_q     <= '0;
      target_q     <= '0;
      hash_q       <= '0;
      nonce        <= '0;
      nonce_end_q  <= '0;
      wait_cnt     <= '0;
      miner_valid  <= 1'b0;
      miner_header <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_nonce <= '0;
      result_hash  <= '0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (abort && (state != IDLE)) begin
        state        <= IDLE;
        busy         <= 1'b0;
        miner_valid  <= 1'b0;
        result_valid <= 1'b0;
        aborted      <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start) begin
            header_q     <= header_in;
            target_q     <= target;
            nonce        <= nonce_start;
            nonce_end_q  <= nonce_end;
            timeout_err  <= 1'b0;
            busy         <= 1'b1;
            miner_valid  <= 1'b1;
            miner_header <= launch_hdr;
            state        <= ISSUE;
          end
          // Entered from an advance with miner_valid low: first build the header, then launch.
          ISSUE: if (miner_valid) begin
            miner_valid <= 1'b0;
            wait_cnt    <= '0;
            state       <= WAIT;
          end else begin
            miner_valid  <= 1'b1;
            miner_header <= launch_hdr;
          end
          WAIT: if (miner_out_valid) begin
            hash_q <= miner_hash;
            state  <= CHECK;
          end else if (wait_cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
          CHECK: if (hash_le) begin
            result_nonce <= nonce;
            result_hash  <= hash_q;
            result_valid <= 1'b1;
            state        <= FOUND;
          end else if (last) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            nonce <= nonce + 1'b1;
            state <= ISSUE;
          end
          FOUND: if (result_ack) begin
            result_valid <= 1'b0;
            if (last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              nonce <= nonce + 1'b1;
              state <= ISSUE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler: a vector table of sweeps against a
// fixed-latency miner model, plus hand sequences for timeout, abort and reset.
module tb_nonce_scheduler;
  import miner_pkg::*;

  localparam int NL  = 96;
  localparam int LAT = 64;

  logic         clk, rst, start_a, start_b, abort, result_ack;
  logic [511:0] header_in;
  logic [255:0] target, miner_hash, man_hash, mdl_hash;
  logic [31:0]  nonce_start, nonce_end;
  logic         miner_out_valid, man_mov, mdl_mov;

  logic         mv_a, busy_a, rv_a, done_a, ab_a, te_a;
  logic [511:0] hdr_a;
  logic [31:0]  rn_a;
  logic [255:0] rh_a;
  logic         mv_b, busy_b, rv_b, done_b, ab_b, te_b;
  logic [511:0] hdr_b;
  logic [31:0]  rn_b;
  logic [255:0] rh_b;

  assign miner_out_valid = mdl_mov | man_mov;
  assign miner_hash      = man_mov ? man_hash : mdl_hash;

  nonce_scheduler dut (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort),
    .header_in(header_in), .target(target),
    .nonce_start(nonce_start), .nonce_end(nonce_end),
    .miner_valid(mv_a), .miner_header(hdr_a),
    .miner_out_valid(miner_out_valid), .miner_hash(miner_hash),
    .busy(busy_a), .result_valid(rv_a), .result_nonce(rn_a), .result_hash(rh_a),
    .result_ack(result_ack), .done(done_a), .aborted(ab_a), .timeout_err(te_a)
  );

  nonce_scheduler #(.NONCE_LSB(NL), .TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort),
    .header_in(header_in), .target(target),
    .nonce_start(nonce_start), .nonce_end(nonce_end),
    .miner_valid(mv_b), .miner_header(hdr_b),
    .miner_out_valid(miner_out_valid), .miner_hash(miner_hash),
    .busy(busy_b), .result_valid(rv_b), .result_nonce(rn_b), .result_hash(rh_b),
    .result_ack(result_ack), .done(done_b), .aborted(ab_b), .timeout_err(te_b)
  );

  typedef struct {
    logic [31:0]  ns;
    logic [31:0]  ne;
    logic [255:0] tgt;
    logic [31:0]  hit;
    bit           use_hit;
    bit           restart;
    int           exp_issues;
    bit           exp_found;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  int checks, errors, cyc, resp_cyc;
  bit model_on, m_use_hit;
  logic [255:0] m_tgt;
  logic [31:0]  m_hit;
  logic [31:0]  issued [$];
  logic [511:0] hdrs [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  function automatic logic [255:0] hash_of(input logic [31:0] n);
    if (m_use_hit && n == m_hit) return m_tgt;
    return m_tgt + 256'(n) + 256'd1;
  endfunction

  function automatic logic [511:0] make_tmpl(input int idx);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(idx) * 32'h0101_0101;
    return {16{w}};
  endfunction

  // Miner model: answers each launch of dut after LAT cycles, one job at a time.
  initial begin : miner_model
    bit          pending;
    int          due;
    logic [31:0] pn;
    pending  = 0;
    due      = 0;
    pn       = '0;
    mdl_mov  = 1'b0;
    mdl_hash = '0;
    resp_cyc = 0;
    forever begin
      @(negedge clk);
      mdl_mov = 1'b0;
      if (pending && cyc == due) begin
        mdl_mov  = 1'b1;
        mdl_hash = hash_of(pn);
        resp_cyc = cyc;
        pending  = 0;
      end
      if (model_on && mv_a) begin
        pn = hdr_a[NL +: 32];
        issued.push_back(pn);
        hdrs.push_back(hdr_a);
        pending = 1;
        due     = cyc + LAT;
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 256'(act), 256'(exp));
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_mv"}, mv_a, 1'b0);
    chk1({tag, "_hdr_zero"}, hdr_a == '0, 1'b1);
    chk1({tag, "_busy"}, busy_a, 1'b0);
    chk1({tag, "_rv"}, rv_a, 1'b0);
    chk({tag, "_rnonce"}, 256'(rn_a), 256'd0);
    chk({tag, "_rhash"}, rh_a, 256'd0);
    chk1({tag, "_done"}, done_a, 1'b0);
    chk1({tag, "_aborted"}, ab_a, 1'b0);
    chk1({tag, "_terr"}, te_a, 1'b0);
    chk1({tag, "_b_busy"}, busy_b, 1'b0);
    chk1({tag, "_b_terr"}, te_b, 1'b0);
    chk1({tag, "_b_hdr_zero"}, hdr_b == '0, 1'b1);
  endtask

  task automatic timeout_seq();
    int n;
    bit bad;
    target      = '1;
    header_in   = make_tmpl(9);
    nonce_start = 32'h100;
    nonce_end   = 32'h105;
    start_b     = 1'b1;
    n           = cyc;
    @(negedge clk);
    start_b = 1'b0;
    chk1("to_launch", mv_b, 1'b1);
    chk("to_launch_nonce", 256'(hdr_b[NL +: 32]), 256'h100);
    while (cyc < n + 17) @(negedge clk);
    chk1("to_err_before", te_b, 1'b0);
    chk1("to_busy_before", busy_b, 1'b1);
    @(negedge clk);
    chk1("to_err_set", te_b, 1'b1);
    chk1("to_busy_drop", busy_b, 1'b0);
    chk1("to_no_done", done_b, 1'b0);
    man_hash = '0;
    man_mov  = 1'b1;
    @(negedge clk);
    man_mov = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (rv_b || mv_b || busy_b || !te_b) bad = 1;
    end
    chk1("to_late_ignored", bad, 1'b0);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk1("to_err_cleared", te_b, 1'b0);
    chk1("to_restart_busy", busy_b, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk1("to_aborted", ab_b, 1'b1);
    chk1("to_abort_mv", mv_b, 1'b0);
    chk1("idle_abort_ignored", ab_a, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int base, s, guard, ack_cyc, hold, cnt;
    bit from_ack, got_res, holding, got_done, hold_bad;
    logic [511:0] tmpl, eh;
    logic [31:0]  en;
    string pfx;
    pfx       = $sformatf("v%0d", idx);
    base      = issued.size();
    m_tgt     = v.tgt;
    m_hit     = v.hit;
    m_use_hit = v.use_hit;
    model_on  = 1;
    tmpl        = make_tmpl(idx);
    header_in   = tmpl;
    target      = v.tgt;
    nonce_start = v.ns;
    nonce_end   = v.ne;
    start_a     = 1'b1;
    s           = cyc;
    @(negedge clk);
    start_a     = 1'b0;
    header_in   = ~tmpl;
    target      = ~v.tgt;
    nonce_start = ~v.ns;
    nonce_end   = v.ns;
    chk1({pfx, "_launch"}, mv_a, 1'b1);
    chk1({pfx, "_busy"}, busy_a, 1'b1);
    from_ack = 0; got_res = 0; holding = 0; got_done = 0; hold_bad = 0;
    hold = 0; guard = 0; ack_cyc = 0;
    while (!got_done && guard < 3000) begin
      @(negedge clk);
      guard++;
      start_a = v.restart && (cyc == s + 10);
      if (start_a) begin
        nonce_start = 32'h900;
        nonce_end   = 32'h900;
      end
      if (result_ack) begin
        result_ack = 1'b0;
        chk1({pfx, "_ack_clear"}, rv_a, 1'b0);
      end
      if (mv_a) begin
        chk({pfx, "_lat_issue"}, 256'(cyc), 256'(from_ack ? ack_cyc + 2 : resp_cyc + 3));
        from_ack = 0;
      end
      if (rv_a && !got_res) begin
        got_res = 1;
        holding = 1;
        hold    = 0;
        chk({pfx, "_lat_result"}, 256'(cyc), 256'(resp_cyc + 2));
        chk({pfx, "_rnonce"}, 256'(rn_a), 256'(v.hit));
        chk({pfx, "_rhash"}, rh_a, v.tgt);
      end
      if (holding) begin
        hold++;
        if (!rv_a || mv_a) hold_bad = 1;
        if (hold == 20) begin
          result_ack = 1'b1;
          ack_cyc    = cyc;
          from_ack   = 1;
          holding    = 0;
        end
      end
      if (done_a) begin
        got_done = 1;
        chk({pfx, "_lat_done"}, 256'(cyc), 256'(from_ack ? ack_cyc + 1 : resp_cyc + 2));
      end
    end
    start_a    = 1'b0;
    result_ack = 1'b0;
    chk1({pfx, "_done_seen"}, got_done, 1'b1);
    @(negedge clk);
    chk1({pfx, "_done_single"}, done_a, 1'b0);
    chk1({pfx, "_idle"}, busy_a, 1'b0);
    cnt = issued.size() - base;
    chk({pfx, "_issues"}, 256'(cnt), 256'(v.exp_issues));
    for (int i = 0; i < cnt && i < v.exp_issues; i++) begin
      en = v.ns + 32'(i);
      eh = tmpl;
      eh[NL +: 32] = en;
      chk($sformatf("%s_nonce%0d", pfx, i), 256'(issued[base + i]), 256'(en));
      chk1($sformatf("%s_hdr%0d", pfx, i), hdrs[base + i] == eh, 1'b1);
    end
    chk1({pfx, "_found"}, got_res, v.exp_found);
    chk1({pfx, "_hold"}, hold_bad, 1'b0);
  endtask

  task automatic abort_seq();
    int s;
    bit bad;
    model_on    = 0;
    target      = '1;
    header_in   = make_tmpl(20);
    nonce_start = 32'h200;
    nonce_end   = 32'h210;
    start_a     = 1'b1;
    s           = cyc;
    @(negedge clk);
    start_a = 1'b0;
    chk1("ab_launch", mv_a, 1'b1);
    while (cyc < s + 5) @(negedge clk);
    man_hash = '0;
    man_mov  = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    man_mov = 1'b0;
    abort   = 1'b0;
    chk1("ab_pulse", ab_a, 1'b1);
    chk1("ab_no_rv", rv_a, 1'b0);
    chk1("ab_busy", busy_a, 1'b0);
    chk1("ab_no_done", done_a, 1'b0);
    @(negedge clk);
    chk1("ab_pulse_end", ab_a, 1'b0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (rv_a || mv_a || busy_a) bad = 1;
    end
    chk1("ab_quiet", bad, 1'b0);
    // Abort while a result is held drops result_valid.
    start_a = 1'b1;
    s       = cyc;
    @(negedge clk);
    start_a = 1'b0;
    while (cyc < s + 5) @(negedge clk);
    man_hash = 256'h1234;
    man_mov  = 1'b1;
    @(negedge clk);
    man_mov = 1'b0;
    @(negedge clk);
    chk1("abf_rv", rv_a, 1'b1);
    chk("abf_rnonce", 256'(rn_a), 256'h200);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk1("abf_pulse", ab_a, 1'b1);
    chk1("abf_rv_clear", rv_a, 1'b0);
  endtask

  task automatic reset_seq();
    model_on    = 1;
    m_use_hit   = 0;
    m_tgt       = '0;
    target      = '0;
    header_in   = make_tmpl(30);
    nonce_start = 32'h40;
    nonce_end   = 32'h41;
    start_a     = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (8) @(negedge clk);
    chk1("rst_pre_busy", busy_a, 1'b1);
    #2 rst = 1'b0;
    #1 check_all_zero("rst_mid");
    model_on = 0;
    repeat (70) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk1("rst_after_busy", busy_a, 1'b0);
    chk1("rst_after_mv", mv_a, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; result_ack = 1'b0;
    man_mov = 1'b0; man_hash = '0;
    header_in = '0; target = '0; nonce_start = '0; nonce_end = '0;
    model_on = 0; m_tgt = '0; m_hit = '0; m_use_hit = 0;

    vecs[0] = '{ns: 32'h10, ne: 32'h13, tgt: 256'h0, hit: 32'h0,
                use_hit: 0, restart: 0, exp_issues: 4, exp_found: 0};
    vecs[1] = '{ns: 32'h10, ne: 32'h13, tgt: 256'h1000, hit: 32'h12,
                use_hit: 1, restart: 0, exp_issues: 4, exp_found: 1};
    vecs[2] = '{ns: 32'hFFFF_FFFE, ne: 32'h1, tgt: 256'h0, hit: 32'h0,
                use_hit: 0, restart: 0, exp_issues: 4, exp_found: 0};
    vecs[3] = '{ns: 32'h55, ne: 32'h55, tgt: 256'h77, hit: 32'h55,
                use_hit: 1, restart: 0, exp_issues: 1, exp_found: 1};
    vecs[4] = '{ns: 32'h30, ne: 32'h32, tgt: 256'h0, hit: 32'h0,
                use_hit: 0, restart: 1, exp_issues: 3, exp_found: 0};
    vecs[5] = '{ns: 32'h7, ne: 32'h8, tgt: {1'b1, 255'd0}, hit: 32'h7,
                use_hit: 1, restart: 0, exp_issues: 2, exp_found: 1};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    timeout_seq();
    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);
    abort_seq();
    reset_seq();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
